// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: commits branch/JAL/JALR redirects and sequences the wrong-path flush window.
// Latency: accepted redirect updates pc and raises flush one edge later; misalign is a registered pulse.
// Backpressure: stall freezes pc and the flush count; a redirect accepted under stall waits in HOLD.
// Optional macro BRANCH_STATS_EN adds the saturating redir_count output.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  redir_sel,
    input  logic        redir_req,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] jalr_tgt,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        flush,
    output logic        busy,
`ifdef BRANCH_STATS_EN
    output logic [31:0] redir_count,
`endif
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    localparam logic [1:0] DEPTH = 2'(FLUSH_DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] pend, pend_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] tgt;
    logic [31:0] pc_seq;
    logic        req_vld;
    logic        accept;

    always_comb begin
        tgt = 32'h0;
        case (redir_sel)
            2'b01:   tgt = branch_tgt;
            2'b10:   tgt = jal_tgt;
            2'b11:   tgt = jalr_tgt & ~32'h1;
            default: tgt = 32'h0;
        endcase
    end

    // Only IDLE listens; anything seen in HOLD/FLUSH is from the wrong path.
    assign req_vld = (state == IDLE) && redir_req && (redir_sel != 2'b00);
    assign accept  = req_vld && !tgt[1];
    assign pc_seq  = pc + 32'd4;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (stall) begin
                        pend_nxt  = tgt;
                        state_nxt = HOLD;
                    end else begin
                        pc_nxt    = tgt;
                        cnt_nxt   = DEPTH;
                        state_nxt = FLUSH;
                    end
                end else if (!stall) begin
                    pc_nxt = pc_seq;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_nxt    = pend;
                    cnt_nxt   = DEPTH;
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_nxt  = pc_seq;
                    cnt_nxt = cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            cnt      <= 2'd0;
            pend     <= 32'h0;
            flush    <= 1'b0;
            busy     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            flush    <= (state_nxt != IDLE);
            busy     <= (state_nxt != IDLE);
            misalign <= req_vld && tgt[1];
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_count <= 32'h0;
        end else if (accept && (redir_count != 32'hFFFF_FFFF)) begin
            redir_count <= redir_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  redir_sel = 2'b00;
    logic        redir_req = 1'b0;
    logic [31:0] branch_tgt = 32'h0;
    logic [31:0] jal_tgt = 32'h0;
    logic [31:0] jalr_tgt = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        flush;
    logic        busy;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [31:0] redir_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending redirect flag/target and remaining flush cycles.
    logic [31:0] m_pc = RST_PC;
    logic        m_pend_v = 1'b0;
    logic [31:0] m_pend = 32'h0;
    int          m_left = 0;
    logic        m_mis = 1'b0;
    logic [31:0] m_cnt = 32'h0;

    pc_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .redir_sel(redir_sel), .redir_req(redir_req),
        .branch_tgt(branch_tgt), .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt), .stall(stall),
        .pc(pc), .flush(flush), .busy(busy),
`ifdef BRANCH_STATS_EN
        .redir_count(redir_count),
`endif
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic m_flush();
        return m_pend_v || (m_left > 0);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_pend_v = 1'b0; m_pend = 32'h0; m_left = 0; m_mis = 1'b0; m_cnt = 32'h0;
    endtask

    // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
    task automatic drive(input logic [1:0] s, input logic r, input logic [31:0] bt,
                         input logic [31:0] jt, input logic [31:0] jrt, input logic st);
        logic [31:0] t;
        redir_sel = s; redir_req = r; branch_tgt = bt; jal_tgt = jt; jalr_tgt = jrt; stall = st;
        case (s)
            2'b01:   t = bt;
            2'b10:   t = jt;
            default: t = jrt & ~32'h1;
        endcase
        m_mis = 1'b0;
        if (m_pend_v) begin
            if (!st) begin m_pc = m_pend; m_pend_v = 1'b0; m_left = DEPTH; end
        end else if (m_left > 0) begin
            if (!st) begin m_pc = m_pc + 32'd4; m_left = m_left - 1; end
        end else if (r && s != 2'b00 && t[1]) begin
            m_mis = 1'b1;
            if (!st) m_pc = m_pc + 32'd4;
        end else if (r && s != 2'b00) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (st) begin m_pend_v = 1'b1; m_pend = t; end
            else begin m_pc = t; m_left = DEPTH; end
        end else if (!st) begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] s, input logic [31:0] t, input logic st);
        drive(s, s != 2'b00, t, t, t, st);
    endtask

    task automatic idle(input logic st);
        drive(2'b00, 1'b0, 32'h0, 32'h0, 32'h0, st);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        redir_sel = 2'b00; redir_req = 1'b0; stall = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b want 0", misalign); end
`ifdef BRANCH_STATS_EN
        n_tests++; if (redir_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", redir_count); end
`endif
        for (int i = 1; i <= 3; i++) begin
            idle(1'b0);
            n_tests++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
            n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL seq_flush%0d: got %b want 0", i, flush); end
        end
    endtask

    task automatic test_branch();
        go(2'b10, 32'h0000_00F8, 1'b0);
        idle(1'b0);
        idle(1'b0);
        n_tests++; if (pc !== 32'h100 || flush !== 1'b0) begin n_fail++; $display("FAIL setup_pc: got %h/%b want 100/0", pc, flush); end
        go(2'b01, 32'h40, 1'b0);
        n_tests++; if (pc !== 32'h40 || flush !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL br_commit: got %h/%b/%b want 40/1/1", pc, flush, busy); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h44 || flush !== 1'b1) begin n_fail++; $display("FAIL br_flush2: got %h/%b want 44/1", pc, flush); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h48 || flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL br_done: got %h/%b/%b want 48/0/0", pc, flush, busy); end
    endtask

    task automatic test_stall_hold();
        go(2'b10, 32'h200, 1'b1);
        n_tests++; if (pc !== 32'h48 || flush !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL hold1: got %h/%b/%b want 48/1/1", pc, flush, busy); end
        idle(1'b1);
        idle(1'b1);
        n_tests++; if (pc !== 32'h48 || flush !== 1'b1) begin n_fail++; $display("FAIL hold3: got %h/%b want 48/1", pc, flush); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h200 || flush !== 1'b1) begin n_fail++; $display("FAIL hold_commit: got %h/%b want 200/1", pc, flush); end
        idle(1'b1);
        n_tests++; if (pc !== 32'h200 || flush !== 1'b1) begin n_fail++; $display("FAIL flush_stall: got %h/%b want 200/1", pc, flush); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h204 || flush !== 1'b1) begin n_fail++; $display("FAIL hold_flush2: got %h/%b want 204/1", pc, flush); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h208 || flush !== 1'b0) begin n_fail++; $display("FAIL hold_done: got %h/%b want 208/0", pc, flush); end
    endtask

    task automatic test_jalr_misalign();
        drive(2'b11, 1'b1, 32'h0, 32'h0, 32'h301, 1'b0);
        n_tests++; if (pc !== 32'h300) begin n_fail++; $display("FAIL jalr_mask: got %h want 300", pc); end
        idle(1'b0);
        idle(1'b0);
        drive(2'b11, 1'b1, 32'h0, 32'h0, 32'h302, 1'b0);
        n_tests++; if (misalign !== 1'b1 || pc !== 32'h30C || flush !== 1'b0) begin n_fail++; $display("FAIL misalign: got %b/%h/%b want 1/30c/0", misalign, pc, flush); end
        idle(1'b0);
        n_tests++; if (misalign !== 1'b0 || pc !== 32'h310) begin n_fail++; $display("FAIL misalign_end: got %b/%h want 0/310", misalign, pc); end
    endtask

    task automatic test_ignore_in_flush();
        go(2'b01, 32'h600, 1'b0);
        go(2'b01, 32'h500, 1'b0);
        n_tests++; if (pc !== 32'h604 || flush !== 1'b1) begin n_fail++; $display("FAIL ignore1: got %h/%b want 604/1", pc, flush); end
        go(2'b10, 32'h500, 1'b0);
        n_tests++; if (pc !== 32'h608 || flush !== 1'b0) begin n_fail++; $display("FAIL ignore2: got %h/%b want 608/0", pc, flush); end
    endtask

    task automatic test_wrap();
        go(2'b10, 32'hFFFF_FFF8, 1'b0);
        idle(1'b0);
        n_tests++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h want fffffffc", pc); end
        idle(1'b0);
        n_tests++; if (pc !== 32'h0 || flush !== 1'b0) begin n_fail++; $display("FAIL wrap: got %h/%b want 0/0", pc, flush); end
    endtask

    task automatic test_reset_mid();
        go(2'b01, 32'h1000, 1'b0);
        rst = 1'b1; model_reset();
        #1;
        n_tests++; if (pc !== RST_PC || flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %h/%b/%b want %h/0/0", pc, flush, busy, RST_PC); end
`ifdef BRANCH_STATS_EN
        n_tests++; if (redir_count !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %h want 0", redir_count); end
`endif
        apply_reset();
        go(2'b10, 32'h2000, 1'b1);
        rst = 1'b1; model_reset();
        #1;
        n_tests++; if (pc !== RST_PC || flush !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %h/%b want %h/0", pc, flush, RST_PC); end
        apply_reset();
        idle(1'b0);
        n_tests++; if (pc !== RST_PC + 32'd4 || flush !== 1'b0) begin n_fail++; $display("FAIL pend_lost: got %h/%b want %h/0", pc, flush, RST_PC + 32'd4); end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            go(2'(i % 3 + 1), 32'h1000 + 32'(i * 64), i == 2);
            idle(1'b0); idle(1'b0); idle(1'b0);
        end
        drive(2'b11, 1'b1, 32'h0, 32'h0, 32'h4002, 1'b0);
        idle(1'b0);
        n_tests++; if (redir_count !== 32'd5) begin n_fail++; $display("FAIL stats_count: got %0d want 5", redir_count); end
    endtask
`endif

    task automatic test_random();
        logic [1:0]  s;
        logic        r, st;
        logic [31:0] bt, jt, jrt;
        for (int i = 0; i < 400; i++) begin
            s   = 2'($urandom_range(0, 3));
            r   = ($urandom_range(0, 9) < 4);
            st  = ($urandom_range(0, 9) < 3);
            bt  = ($urandom & ~32'h3) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
            jt  = ($urandom & ~32'h3) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
            jrt = ($urandom & ~32'h3) | 32'($urandom_range(0, 1)) | (($urandom_range(0, 5) == 0) ? 32'h2 : 32'h0);
            drive(s, r, bt, jt, jrt, st);
            n_tests++;
            if (pc !== m_pc || flush !== m_flush() || busy !== m_flush() || misalign !== m_mis) begin
                n_fail++;
                $display("FAIL rand%0d: got pc=%h fl=%b bz=%b mis=%b want pc=%h fl=%b bz=%b mis=%b",
                         i, pc, flush, busy, misalign, m_pc, m_flush(), m_flush(), m_mis);
            end
`ifdef BRANCH_STATS_EN
            n_tests++;
            if (redir_count !== m_cnt) begin n_fail++; $display("FAIL rand_count%0d: got %0d want %0d", i, redir_count, m_cnt); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_hold();
        test_jalr_misalign();
        test_ignore_in_flush();
        test_wrap();
        test_reset_mid();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        apply_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
